// File: rtl/serial_add_sub_if.sv
// Operand/result bundle for serial_add_sub.
// master: the requester driving start/sub/a/b; slave: the serial adder itself.
interface serial_add_sub_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             zf;
  logic             sf;
  logic             of;

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout, zf, sf, of
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout, zf, sf, of
  );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: a single full-adder slice walks the operands LSB first,
// one bit per clock. Subtraction is a + ~b + 1, with the +1 preloaded into the carry.
// Optional build macro FLAGS_EN registers zero/sign/signed-overflow flags on entry to DONE;
// without it zf/sf/of are tied to 0.
module serial_add_sub #(
  parameter int unsigned WIDTH = 64
) (
  input logic             clk,
  input logic             rst_n,
  serial_add_sub_if.slave bus
);

  localparam int unsigned IdxW = $clog2(WIDTH);
  // One extra bit so the counter can reach WIDTH without wrapping.
  localparam int unsigned CntW = IdxW + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;

  logic [IdxW-1:0]  idx;
  logic             cnt_last;
  logic             accept;
  logic             sum_bit;
  logic             carry_bit;

  assign idx      = cnt_q[IdxW-1:0];
  // All WIDTH bits are done; this RUN cycle only moves to DONE.
  assign cnt_last = (cnt_q == CntLast);
  assign accept   = (state_q == StIdle) && bus.start;

  // Single full-adder slice on the current bit position.
  assign sum_bit   = opa_q[idx] ^ opb_q[idx] ^ carry_q;
  assign carry_bit = (opa_q[idx] & opb_q[idx]) | (carry_q & (opa_q[idx] ^ opb_q[idx]));

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (cnt_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.busy = (state_q != StIdle);
    bus.done = (state_q == StDone);
  end

  // Datapath next state: capture on accept, one bit per RUN cycle otherwise hold.
  always_comb begin
    opa_d    = opa_q;
    opb_d    = opb_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (accept) begin
      opa_d   = bus.a;
      opb_d   = bus.b ^ {WIDTH{bus.sub}};
      carry_d = bus.sub;
      cnt_d   = '0;
    end else if ((state_q == StRun) && !cnt_last) begin
      result_d[idx] = sum_bit;
      carry_d       = carry_bit;
      cnt_d         = cnt_q + CntW'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q    <= '0;
      opb_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign bus.result = result_q;
  // Final carry flop doubles as cout; for subtract 1 means no borrow.
  assign bus.cout   = carry_q;

`ifdef FLAGS_EN
  logic zf_q, zf_d;
  logic sf_q, sf_d;
  logic of_q, of_d;
  logic flag_load;

  assign flag_load = (state_q == StRun) && cnt_last;

  // Flag next state: computed from the finished result on the RUN->DONE edge.
  always_comb begin
    zf_d = zf_q;
    sf_d = sf_q;
    of_d = of_q;
    if (flag_load) begin
      zf_d = (result_q == '0);
      sf_d = result_q[WIDTH-1];
      of_d = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) && (result_q[WIDTH-1] != opa_q[WIDTH-1]);
    end
  end

  // Flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q <= 1'b0;
      sf_q <= 1'b0;
      of_q <= 1'b0;
    end else begin
      zf_q <= zf_d;
      sf_q <= sf_d;
      of_q <= of_d;
    end
  end

  assign bus.zf = zf_q;
  assign bus.sf = sf_q;
  assign bus.of = of_q;
`else
  assign bus.zf = 1'b0;
  assign bus.sf = 1'b0;
  assign bus.of = 1'b0;
`endif

endmodule

// File: doc/serial_add_sub.md
SERIAL_ADD_SUB -- requirements
Module: serial_add_sub

Interface
REQ-001 Parameter WIDTH, default 64, is the operand and result width in bits; legal values are 2..64.
REQ-002 clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  is the reset: asynchronous, active-low.
REQ-004 start  input  1  is the operation request; it is sampled only in IDLE.
REQ-005 sub  input  1  selects the operation: 0 = a+b, 1 = a-b; it is sampled with start.
REQ-006 a, b  input  WIDTH  are the operands, sampled with start.
REQ-007 busy  output  1  is high while an operation is in progress (RUN or DONE).
REQ-008 done  output  1  is a one-cycle pulse marking the result as valid.
REQ-009 result  output  WIDTH  is the sum or difference.
REQ-010 cout  output  1  is the carry out of the MSB; for subtract, 1 means no borrow.
REQ-011 zf, sf, of  output  1 each  are the zero, sign and signed-overflow flags of result.

Function
REQ-012 The datapath SHALL be one full-adder bit slice reused serially, LSB first, one bit per clock; there is no parallel adder.
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE -> RUN on start=1.
- RUN -> DONE after the WIDTH-th bit.
- DONE -> IDLE unconditionally after one cycle.
REQ-014 On start in IDLE, the block SHALL capture:
- opA = a
- opB = b XOR {WIDTH{sub}}
- carry = sub
- bit counter = 0
REQ-015 Each RUN cycle SHALL compute the sum and carry-out of (opA[cnt], opB[cnt], carry), write the sum to result[cnt], update the carry flop, and increment cnt.
REQ-016 Latency: start sampled at edge N -> bits processed at edges N+1..N+WIDTH -> done=1 in the cycle after edge N+WIDTH+1.
REQ-017 done SHALL be high for exactly one cycle, in DONE.
REQ-018 result, cout and the flags SHALL hold their values from DONE until the next accepted start.
REQ-019 start in RUN or DONE SHALL be ignored; it is not queued, and the operands are not re-sampled.
REQ-020 start in the same cycle that DONE returns to IDLE SHALL NOT be accepted; it is accepted in the next IDLE cycle.
REQ-021 Arithmetic SHALL be modulo 2^WIDTH.
REQ-022 cout SHALL be the final carry flop value.
REQ-023 of SHALL be 1 when opA[MSB]==opB[MSB] and result[MSB]!=opA[MSB].
REQ-024 The bit counter SHALL be clog2(WIDTH)+1 bits wide and SHALL NOT wrap during RUN.

Reset
REQ-025 While rst_n=0, the block SHALL be in IDLE with busy=0, done=0, result=0, cout=0, zf=0, sf=0, of=0, counter=0 and carry=0.
REQ-026 Reset asserted in RUN or DONE SHALL abort the operation immediately; no done pulse SHALL follow.
REQ-027 After rst_n deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-028 With FLAGS_EN defined, zf, sf and of SHALL be registered on entry to DONE:
- zf = (result==0)
- sf = result[MSB]
- of per REQ-023
REQ-029 Without FLAGS_EN, zf, sf and of SHALL be constant 0 and the flag logic SHALL be absent; cout is unaffected.

Verification
REQ-030 The bench SHALL cover these directed scenarios (WIDTH=64):
- Add: a=5, b=7, sub=0 -> done 65 cycles after start, result=12, cout=0, zf=0, sf=0, of=0.
- Subtract to zero: a=9, b=9, sub=1 -> result=0, cout=1, zf=1 (FLAGS_EN).
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> result=0x8000_0000_0000_0000, sf=1, of=1, cout=0.
- Wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=1 -> result=0, cout=1, zf=1, of=0.
- Start while busy: start pulsed at cycle 10 of RUN with new operands -> result unchanged from the first operation; exactly one done pulse.
- Reset at cycle 30 of RUN -> all outputs 0, busy=0, no done pulse; a following start of 2+3 gives result=5.
